chroni_vram_arbiter: RTL
========================

# chroni_vram_arbiter

Single-port VRAM arbiter between the chroni video fetch engine and the CPU. It serves chroni's `rd_req`/`rd_ack` read handshake and CPU byte reads and writes onto one synchronous block RAM. Video reads have priority, and an optional starvation guard bounds CPU wait. It sits directly upstream of chroni, driving its `data_in` and `rd_ack`.

## Interface
Parameters:
- `RAM_AW`, default 16: RAM address width. RAM address = `{page, addr}` truncated to `RAM_AW` LSBs.
- `RAM_LAT`, default 1 (legal 1–4): cycles from `ram_addr` valid to `ram_rdata` valid.
- `CPU_MAX_WAIT`, default 32 (legal 1–255): starvation threshold in cycles. Only used with `CHRONI_VRAM_STARVE_EN`.

Ports:
- `vga_clk` in 1: clock. All logic in this single domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `vid_addr` in 13: chroni `addr_out`.
- `vid_page` in 8: chroni `addr_out_page`.
- `vid_rd_req` in 1: chroni read request, level.
- `vid_rd_ack` out 1: one-cycle pulse; `vid_data` valid.
- `vid_data` out 8: read data, registered, held until the next video ack.
- `cpu_vram_addr` in 21: `{page, addr}`.
- `cpu_vram_wdata` in 8: write data.
- `cpu_vram_we` in 1: write request, level.
- `cpu_vram_re` in 1: read request, level.
- `cpu_vram_rdata` out 8: read data, registered, held until the next CPU read ack.
- `cpu_vram_ready` out 1: one-cycle completion pulse.
- `ram_addr` out `RAM_AW`: RAM address.
- `ram_we` out 1: RAM write strobe.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data.

## Operation
- **States:** IDLE, VID_RD, VID_ACK, CPU_RD, CPU_WR, CPU_ACK.
- **IDLE arbitration:**
  - Video wins if `vid_rd_req`=1.
  - CPU wins otherwise if `cpu_vram_we` or `cpu_vram_re` is set.
  - The starved CPU overrides video (see Configuration).
  - Requests are sampled only in IDLE. Address and data are latched at grant.
- **VID_RD / CPU_RD:** drive the latched `ram_addr`. Count `RAM_LAT` cycles, then capture `ram_rdata` into `vid_data` or `cpu_vram_rdata`, assert the ack, and go to VID_ACK or CPU_ACK.
- **CPU_WR:** `ram_we`=1 for exactly one cycle with the latched address and data, then go to CPU_ACK.
- **VID_ACK / CPU_ACK:** the ack pulse cycle. Always followed by IDLE.
- **Minimum one IDLE cycle between transactions.** Chroni changes `addr_out` on the edge where it sees `rd_ack` while holding `rd_req`. The IDLE cycle samples the new address, never the stale one.
- **Held requests:** a request held high after its ack is treated as a new request.
- **Simultaneous CPU `we` and `re`:** the write is performed, and `cpu_vram_ready` completes the write only.
- **Address changes while busy:** changes to `vid_addr`, `vid_page` or `cpu_vram_addr` mid-transaction are ignored.
- **Reset values:**
  - State is IDLE.
  - `vid_rd_ack`, `cpu_vram_ready`, `ram_we` = 0.
  - `vid_data`, `cpu_vram_rdata`, `ram_addr`, `ram_wdata` = 0.
  - The starvation counter is 0.
- **Reset mid-transaction:** abort with no ack and no further `ram_we`. A started write is not retried.

## Timing
Cycle 0 is the IDLE cycle in which the request is seen.
- **Video or CPU read:**
  - `ram_addr` is valid from cycle 1.
  - Data is captured at the end of cycle 1+`RAM_LAT`.
  - The ack is high in cycle 2+`RAM_LAT` (cycle 3 at `RAM_LAT`=1).
  - IDLE is in cycle 3+`RAM_LAT`.
- **CPU write:** `ram_we`=1 in cycle 1, `cpu_vram_ready`=1 in cycle 2, IDLE in cycle 3.
- **Back-to-back video reads with `rd_req` held:** one read per 3+`RAM_LAT` cycles (4 at default).
- **All outputs are registered.** No combinational path from any input to any output.

## Configuration
- **`CHRONI_VRAM_STARVE_EN` defined:**
  - An 8-bit saturating counter increments every cycle a CPU request is pending and not granted.
  - When the counter is ≥`CPU_MAX_WAIT`, the next IDLE grants the CPU even if `vid_rd_req`=1.
  - The counter clears on CPU grant.
- **Not defined:** strict video priority. The CPU waits indefinitely while video requests continue. No counter logic is synthesised.

## Test plan
- **Single video read:** reset, RAM[0x2401]=0x41, `vid_page`=1, `vid_addr`=0x0401, raise `vid_rd_req` in IDLE -> `ram_addr`=0x2401 from cycle 1; `vid_rd_ack` pulses in cycle 3 with `vid_data`=0x41.
- **Chroni-style chain:** hold `rd_req`, change the address to `{0x41, 3'd2}` on the ack edge, RAM[0x20A]=0x7E -> second ack 4 cycles after the first with `vid_data`=0x7E; the first address is never re-read.
- **CPU write then read:** write 0x5A to 0x00123 -> `ram_we` pulses in cycle 1, ready in cycle 2; then read 0x00123 -> `cpu_vram_rdata`=0x5A with ready in cycle 3.
- **Simultaneous requests:** video and CPU read raised in the same cycle -> video ack first; the CPU read is granted in the following IDLE and acked 4 cycles after the video ack.
- **Starvation guard:** with the macro and `CPU_MAX_WAIT`=4, video `rd_req` held continuously and a CPU write pending -> the CPU is granted at the first IDLE after 4 waiting cycles. Without the macro, no `ram_we` ever occurs while video is held.
- **Reset mid-read:** assert `reset_n`=0 in cycle 1 of a video read -> no `vid_rd_ack`, all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/chroni_vram_arbiter.sv
// chroni_vram_arbiter
// Single-port VRAM arbiter between the chroni video fetch engine and the CPU.
// Video reads have priority. All outputs are registered and there is a
// minimum of one IDLE cycle between transactions, so chroni's address update
// on the ack edge is always sampled fresh.
//
// Optional feature macro: CHRONI_VRAM_STARVE_EN
//   When defined, a saturating wait counter lets a starved CPU request
//   override video priority once it reaches CPU_MAX_WAIT cycles.
//
// Parameters:
//   RAM_AW        RAM address width ({page, addr} truncated to RAM_AW LSBs)
//   RAM_LAT       cycles from ram_addr valid to ram_rdata valid (1..4)
//   CPU_MAX_WAIT  starvation threshold in cycles (1..255)
//
// Ports:
//   vga_clk, reset_n        clock, synchronous active-low reset
//   vid_addr/vid_page       chroni read address (13-bit addr, 8-bit page)
//   vid_rd_req/vid_rd_ack   chroni level request / one-cycle ack pulse
//   vid_data                video read data, held until next video ack
//   cpu_vram_addr           CPU {page, addr}
//   cpu_vram_wdata          CPU write data
//   cpu_vram_we/re          CPU write / read requests (level)
//   cpu_vram_rdata          CPU read data, held until next CPU read ack
//   cpu_vram_ready          one-cycle CPU completion pulse
//   ram_addr/we/wdata/rdata synchronous block RAM port
//
// States:
//   state     | meaning
//   IDLE      | sample requests and latch address/data of the winner
//   VID_RD    | video read in flight, waiting RAM_LAT cycles
//   VID_ACK   | vid_rd_ack pulse cycle
//   CPU_RD    | CPU read in flight, waiting RAM_LAT cycles
//   CPU_WR    | ram_we asserted for this single cycle
//   CPU_ACK   | cpu_vram_ready pulse cycle
module chroni_vram_arbiter #(
  parameter int RAM_AW       = 16,
  parameter int RAM_LAT      = 1,
  parameter int CPU_MAX_WAIT = 32
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [12:0]       vid_addr,
  input  logic [7:0]        vid_page,
  input  logic              vid_rd_req,
  output logic              vid_rd_ack,
  output logic [7:0]        vid_data,
  input  logic [20:0]       cpu_vram_addr,
  input  logic [7:0]        cpu_vram_wdata,
  input  logic              cpu_vram_we,
  input  logic              cpu_vram_re,
  output logic [7:0]        cpu_vram_rdata,
  output logic              cpu_vram_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_VID_RD, S_VID_ACK, S_CPU_RD, S_CPU_WR, S_CPU_ACK
  } state_t;

  localparam logic [2:0] LAT_LOAD  = 3'(RAM_LAT);
  localparam logic [7:0] MAX_WAIT8 = 8'(CPU_MAX_WAIT);

  state_t     state, next_state;
  logic [2:0] lat_cnt;
  logic       lat_done;
  logic       cpu_req;
  logic       starve_hit;
  logic       vid_grant, cpu_rd_grant, cpu_wr_grant;
  logic       vid_capture, cpu_capture;

  assign cpu_req  = cpu_vram_we | cpu_vram_re;
  assign lat_done = (lat_cnt == 3'd0);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        // Write wins over a simultaneous read from the CPU.
        if (cpu_req && starve_hit) next_state = cpu_vram_we ? S_CPU_WR : S_CPU_RD;
        else if (vid_rd_req)       next_state = S_VID_RD;
        else if (cpu_vram_we)      next_state = S_CPU_WR;
        else if (cpu_vram_re)      next_state = S_CPU_RD;
      end
      S_VID_RD:  if (lat_done) next_state = S_VID_ACK;
      S_CPU_RD:  if (lat_done) next_state = S_CPU_ACK;
      S_CPU_WR:  next_state = S_CPU_ACK;
      S_VID_ACK: next_state = S_IDLE;
      S_CPU_ACK: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    vid_grant    = (state == S_IDLE) && (next_state == S_VID_RD);
    cpu_rd_grant = (state == S_IDLE) && (next_state == S_CPU_RD);
    cpu_wr_grant = (state == S_IDLE) && (next_state == S_CPU_WR);
    vid_capture  = (state == S_VID_RD) && lat_done;
    cpu_capture  = (state == S_CPU_RD) && lat_done;
  end

  // Registered outputs and datapath; every output is a flop.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vid_rd_ack     <= 1'b0;
      vid_data       <= 8'h00;
      cpu_vram_rdata <= 8'h00;
      cpu_vram_ready <= 1'b0;
      ram_addr       <= '0;
      ram_we         <= 1'b0;
      ram_wdata      <= 8'h00;
      lat_cnt        <= 3'd0;
    end else begin
      vid_rd_ack     <= vid_capture;
      cpu_vram_ready <= cpu_capture || (state == S_CPU_WR);
      ram_we         <= cpu_wr_grant;
      if (vid_grant)
        ram_addr <= RAM_AW'({vid_page, vid_addr});
      else if (cpu_rd_grant || cpu_wr_grant)
        ram_addr <= RAM_AW'(cpu_vram_addr);
      if (cpu_wr_grant) ram_wdata <= cpu_vram_wdata;
      // Down-counter: loaded with RAM_LAT at grant, data is valid at zero.
      if (vid_grant || cpu_rd_grant) lat_cnt <= LAT_LOAD;
      else if (!lat_done)            lat_cnt <= lat_cnt - 3'd1;
      if (vid_capture) vid_data       <= ram_rdata;
      if (cpu_capture) cpu_vram_rdata <= ram_rdata;
    end
  end

`ifdef CHRONI_VRAM_STARVE_EN
  logic [7:0] starve_cnt;
  logic       cpu_busy;

  // Waiting only counts while the CPU is not itself being served.
  assign cpu_busy   = (state == S_CPU_RD) || (state == S_CPU_WR) || (state == S_CPU_ACK);
  assign starve_hit = (starve_cnt >= MAX_WAIT8);

  always_ff @(posedge vga_clk) begin
    if (!reset_n)
      starve_cnt <= 8'd0;
    else if (cpu_rd_grant || cpu_wr_grant)
      starve_cnt <= 8'd0;
    else if (cpu_req && !cpu_busy && (starve_cnt != 8'hFF))
      starve_cnt <= starve_cnt + 8'd1;
  end
`else
  logic [7:0] unused_max_wait;

  assign starve_hit      = 1'b0;
  assign unused_max_wait = MAX_WAIT8;
`endif

endmodule
